// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_DATA_BITS  = 8;

    // The parity bit makes the total count of ones over data and parity odd.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one PS/2 line.
// The filtered output changes only after FILT_LEN equal synchronised samples.
module ps2_sync_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_50,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic fall
);

    localparam int CNT_W = $clog2(FILT_LEN);

    logic [1:0]       r_sync;
    logic             r_filt;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync;

    assign w_sync = r_sync[1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse the synchroniser.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_filt <= 1'b1;
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            r_fall <= 1'b0;
            if (w_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
                r_fall <= r_filt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign filt = r_filt;
    assign fall = r_fall;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with scan-code FIFO and byte history, all in clk_50.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into per-entry flags.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 5000,
    parameter int DEPTH       = 8,
    parameter int HIST_N      = 3
) (
    input  logic                    clk_50,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    output logic [7:0]              code_data,
    output logic                    code_valid,
    input  logic                    code_ready,
    output logic                    code_ext,
    output logic                    code_brk,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic                    frame_err,
    output logic                    busy,
    output logic [8*HIST_N-1:0]     hist
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int BIT_W  = $clog2(PS2_DATA_BITS);
    localparam int HIST_W = 8 * HIST_N;
`ifdef PS2_PREFIX_DECODE_EN
    localparam int FIFO_W = 10;
`else
    localparam int FIFO_W = 8;
`endif

    logic w_clk_filt_unused, w_clk_fall;
    logic w_data_f, w_data_fall_unused;

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk_50 (clk_50),
        .rst    (rst),
        .raw    (ps2_clk),
        .filt   (w_clk_filt_unused),
        .fall   (w_clk_fall)
    );

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
        .clk_50 (clk_50),
        .rst    (rst),
        .raw    (ps2_data),
        .filt   (w_data_f),
        .fall   (w_data_fall_unused)
    );

    ps2_state_e       r_state, w_state_nxt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_good, r_frame_err;
    logic             w_shift_en, w_par_en, w_bit_clr, w_good_nxt, w_err_nxt, w_timeout;

    // r_to_cnt holds the number of cycles elapsed since the last strobe, so
    // frame_err lands exactly TIMEOUT_CYC cycles after it (TIMEOUT_CYC >= 2).
    assign w_timeout = (r_state != IDLE) && !w_clk_fall && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_bit_clr   = 1'b0;
        w_good_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
        end else if (w_clk_fall) begin
            case (r_state)
                IDLE: if (!w_data_f) begin
                    w_state_nxt = DATA;
                    w_bit_clr   = 1'b1;
                end
                DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == BIT_W'(PS2_DATA_BITS - 1)) w_state_nxt = PARITY;
                end
                PARITY: begin
                    w_par_en    = 1'b1;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    if (w_data_f && odd_parity_ok(r_shift, r_par)) w_good_nxt = 1'b1;
                    else                                           w_err_nxt  = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_to_cnt    <= '0;
            r_good      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_good      <= w_good_nxt;
            r_frame_err <= w_err_nxt;
            if (w_bit_clr)       r_bit_cnt <= '0;
            else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift_en) r_shift <= {w_data_f, r_shift[7:1]};
            if (w_par_en)   r_par   <= w_data_f;
            if (w_clk_fall)                          r_to_cnt <= TO_W'(1);
            else if (r_to_cnt != TO_W'(TIMEOUT_CYC)) r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    logic              w_push_req;
    logic [FIFO_W-1:0] w_entry, w_head;

`ifdef PS2_PREFIX_DECODE_EN
    logic r_pend_ext, r_pend_brk, w_is_prefix;

    assign w_is_prefix = (r_shift == PS2_PREFIX_EXT) || (r_shift == PS2_PREFIX_BRK);
    assign w_push_req  = r_good && !w_is_prefix;
    assign w_entry     = {r_pend_ext, r_pend_brk, r_shift};

    always_ff @(posedge clk_50) begin
        if (rst || r_frame_err) begin
            r_pend_ext <= 1'b0;
            r_pend_brk <= 1'b0;
        end else if (r_good) begin
            if (r_shift == PS2_PREFIX_EXT)      r_pend_ext <= 1'b1;
            else if (r_shift == PS2_PREFIX_BRK) r_pend_brk <= 1'b1;
            else begin
                r_pend_ext <= 1'b0;
                r_pend_brk <= 1'b0;
            end
        end
    end

    assign code_ext = code_valid & w_head[9];
    assign code_brk = code_valid & w_head[8];
`else
    assign w_push_req = r_good;
    assign w_entry    = r_shift;
    assign code_ext   = 1'b0;
    assign code_brk   = 1'b0;
`endif

    logic [FIFO_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic [HIST_W-1:0] r_hist;
    logic              w_full, w_valid, w_pop, w_push, w_drop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && code_ready;
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;

    // NOTE: the storage array is not reset; the head is masked while empty,
    // so stale contents are never visible and the array stays plain registers.
    always_ff @(posedge clk_50) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_hist     <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
            if (r_good) r_hist <= HIST_W'({r_hist, r_shift});
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign code_data  = w_valid ? w_head[7:0] : 8'h00;
    assign code_valid = w_valid;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != IDLE);
    assign hist       = r_hist;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: stimulus queues expected codes, a monitor
// pops and compares them on every accepted head byte.
module tb_ps2_rx_fifo;

    localparam int FILT_LEN    = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int DEPTH       = 8;
    localparam int HIST_N      = 3;
    localparam int HALF        = 30;

    logic                   clk_50 = 1'b0;
    logic                   rst = 1'b1;
    logic                   ps2_clk = 1'b1;
    logic                   ps2_data = 1'b1;
    logic                   code_ready = 1'b1;
    logic [7:0]             code_data;
    logic                   code_valid, code_ext, code_brk;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow, frame_err, busy;
    logic [8*HIST_N-1:0]    hist;

    ps2_rx_fifo #(
        .FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .DEPTH(DEPTH), .HIST_N(HIST_N)
    ) dut (
        .clk_50(clk_50), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code_data(code_data), .code_valid(code_valid), .code_ready(code_ready),
        .code_ext(code_ext), .code_brk(code_brk), .fifo_count(fifo_count),
        .overflow(overflow), .frame_err(frame_err), .busy(busy), .hist(hist)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct packed {
        logic [7:0] data;
        logic       ext;
        logic       brk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   err_seen = 0;
    int   exp_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        logic p;
        p = ~(^d) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic expect_code(input logic [7:0] d, input logic ext, input logic brk);
        exp_t e;
        e.data = d;
        e.ext  = ext;
        e.brk  = brk;
        exp_q.push_back(e);
    endtask

    // Monitor: consumes the scoreboard whenever the DUT hands over a byte.
    always @(negedge clk_50) begin
        if (!rst) begin
            if (frame_err) err_seen++;
            if (code_valid && code_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got code 0x%0h with nothing expected", code_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("code_data", 32'(code_data), 32'(e.data));
                    check("code_ext", 32'(code_ext), 32'(e.ext));
                    check("code_brk", 32'(code_brk), 32'(e.brk));
                    pops++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic busy_prev, busy_any;

        // Reset state
        wait_cyc(4);
        check("rst_code_data", 32'(code_data), 0);
        check("rst_code_valid", 32'(code_valid), 0);
        check("rst_ext_brk", 32'({code_ext, code_brk}), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_hist", 32'(hist), 0);
        rst = 1'b0;
        wait_cyc(5);

        // Good frame 0x1C
        expect_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("good_pops", 32'(pops), 1);
        check("good_hist", 32'(hist), 32'h00001C);
        check("good_no_err", 32'(err_seen), 0);
        check("good_empty", 32'(fifo_count), 0);

        // Parity error
        send_frame(8'h1C, 1'b1);
        exp_err = 1;
        check("par_err_count", 32'(err_seen), 32'(exp_err));
        check("par_hist", 32'(hist), 32'h00001C);
        check("par_empty", 32'(fifo_count), 0);
        check("par_pops", 32'(pops), 1);

        // Timeout 5 edges into a frame
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        n = 0;
        busy_prev = 1'b0;
        while (n < 2 + FILT_LEN + TIMEOUT_CYC + 50) begin
            busy_prev = busy;
            wait_cyc(1);
            n++;
            if (n == HALF) ps2_clk = 1'b1;
            if (frame_err) break;
        end
        exp_err = 2;
        check("timeout_latency", 32'(n), 32'(2 + FILT_LEN + TIMEOUT_CYC));
        check("timeout_busy_before", 32'(busy_prev), 1);
        check("timeout_busy_after", 32'(busy), 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(100);
        check("timeout_err_count", 32'(err_seen), 32'(exp_err));
        expect_code(8'h32, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0);
        check("after_to_pops", 32'(pops), 2);
        check("after_to_hist", 32'(hist), 32'h001C32);

        // Short glitches on ps2_clk in IDLE
        busy_any = 1'b0;
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            for (int k = 0; k < 20; k++) begin
                wait_cyc(1);
                busy_any = busy_any | busy;
            end
        end
        check("glitch_busy", 32'(busy_any), 0);
        check("glitch_err", 32'(err_seen), 32'(exp_err));

        // Overflow: DEPTH+1 codes with the consumer stalled
        code_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            if (i <= DEPTH) expect_code(8'(i), 1'b0, 1'b0);
            send_frame(8'(i), 1'b0);
        end
        check("ovf_count", 32'(fifo_count), 8);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_hist", 32'(hist), 32'h070809);
        check("ovf_head", 32'(code_data), 32'h01);
        wait_cyc(5);
        check("ovf_head_hold", 32'(code_data), 32'h01);
        check("ovf_valid", 32'(code_valid), 1);
        code_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            wait_cyc(1);
            n++;
        end
        wait_cyc(2);
        check("drain_pops", 32'(pops), 10);
        check("drain_empty", 32'(fifo_count), 0);
        check("drain_ovf_sticky", 32'(overflow), 1);

        // Prefix bytes E0, F0, 75
`ifdef PS2_PREFIX_DECODE_EN
        expect_code(8'h75, 1'b1, 1'b1);
`else
        expect_code(8'hE0, 1'b0, 1'b0);
        expect_code(8'hF0, 1'b0, 1'b0);
        expect_code(8'h75, 1'b0, 1'b0);
`endif
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
        check("prefix_pops", 32'(pops), 11);
`else
        check("prefix_pops", 32'(pops), 13);
`endif
        check("prefix_hist", 32'(hist), 32'hE0F075);

        // Reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        ps2_data = 1'b1;
        wait_cyc(1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ovf", 32'(overflow), 0);
        check("midrst_hist", 32'(hist), 0);
        wait_cyc(TIMEOUT_CYC + 50);
        check("midrst_no_err", 32'(err_seen), 32'(exp_err));
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
